// File: rtl/volume_control.sv
// volume_control: edge-detected accelerated volume target, ramped output level, valid/ready delivery
module volume_control #(
  parameter int WIDTH        = 8,
  parameter int MAX_LEVEL    = 200,
  parameter int RESET_LEVEL  = 100,
  parameter int FAST_STEP    = 4,
  parameter int ACCEL_WINDOW = 12_500_000,
  parameter int RAMP_DIV     = 50_000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Up,
  input  logic             Down,
  input  logic             Mute,
  input  logic             Ready,
  output logic [WIDTH-1:0] Level,
  output logic             Muted,
  output logic             Valid
);
  localparam int AW = $clog2(ACCEL_WINDOW + 1);
  localparam int PW = $clog2(RAMP_DIV + 1);
  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_LEVEL);
  localparam logic [AW-1:0] WIN = AW'(ACCEL_WINDOW);
  localparam logic [PW-1:0] PMAX = PW'(RAMP_DIV - 1);
  logic [WIDTH-1:0] target_q, target_d, level_q, level_d, eff, t_up, t_dn;
  logic [AW-1:0] accel_q, accel_d;
  logic [PW-1:0] pre_q, pre_d;
  logic muted_q, muted_d, valid_q, valid_d, dir_q, dir_d, up_q, dn_q;
  logic up_ev, dn_ev, step, tick, move;
  logic [WIDTH:0] size, sum;
  always_comb begin
    up_ev    = Up & ~up_q;
    dn_ev    = Down & ~dn_q;
    step     = up_ev ^ dn_ev;
    size     = (accel_q < WIN && up_ev == dir_q) ? (WIDTH+1)'(FAST_STEP) : (WIDTH+1)'(1);
    sum      = {1'b0, target_q} + size;
    t_up     = sum > {1'b0, MAX_L} ? MAX_L : sum[WIDTH-1:0];
    t_dn     = {1'b0, target_q} < size ? '0 : target_q - size[WIDTH-1:0];
    target_d = step ? (up_ev ? t_up : t_dn) : target_q;
    dir_d    = step ? up_ev : dir_q;
    accel_d  = step ? '0 : accel_q == WIN ? accel_q : accel_q + 1'b1;
    muted_d  = step ? 1'b0 : muted_q ^ Mute;
    eff      = muted_q ? '0 : target_q;
    tick     = pre_q == PMAX;
    pre_d    = tick ? '0 : pre_q + 1'b1;
    move     = tick && level_q != eff && !(valid_q && !Ready);
    level_d  = move ? (level_q < eff ? level_q + 1'b1 : level_q - 1'b1) : level_q;
    valid_d  = move | (valid_q & ~Ready);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      target_q <= WIDTH'(RESET_LEVEL);
      level_q  <= '0;
      muted_q  <= 1'b0;
      valid_q  <= 1'b0;
      accel_q  <= WIN;
      pre_q    <= '0;
      dir_q    <= 1'b0;
      up_q     <= 1'b1;
      dn_q     <= 1'b1;
    end else begin
      target_q <= target_d;
      level_q  <= level_d;
      muted_q  <= muted_d;
      valid_q  <= valid_d;
      accel_q  <= accel_d;
      pre_q    <= pre_d;
      dir_q    <= dir_d;
      up_q     <= Up;
      dn_q     <= Down;
    end
  end
  assign Level = level_q;
  assign Muted = muted_q;
  assign Valid = valid_q;
endmodule
